// File: rtl/rom_dyn_reader_if.sv
// Read-port bundle for rom_dyn_reader.
// The request channel carries an address into the reader. The result channel
// returns the word that was read, together with its address, to the display
// consumer. The slave modport is the reader side; the master modport is the
// requester/consumer side.
interface rom_dyn_reader_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] display;

  modport master (
    output req_valid, req_addr, rd_ready,
    input  req_ready, rd_valid, rd_addr, display
  );

  modport slave (
    input  req_valid, req_addr, rd_ready,
    output req_ready, rd_valid, rd_addr, display
  );
endinterface

// File: rtl/rom_dyn_reader.sv
// rom_dyn_reader: DEPTH x DATA_W precharged NOR word store.
// Each read runs through a sequenced cycle: precharge (bitlines pulled high
// for PRE_CYC clocks), then one evaluate clock (bitlines discharged where the
// stored bit is 1), then a hold phase. During the hold phase the word sits on
// display until the consumer takes it.
// Reads come either from the valid/ready request port or, while sweep_en is
// high, from an internal pointer that walks 0..DEPTH-1 continuously. The
// sweep has priority over the request port.
// Word k of the store is INIT[k*DATA_W +: DATA_W]. Any bit beyond the 64-bit
// INIT image reads as 0.
module rom_dyn_reader #(
  parameter int          DATA_W  = 8,
  parameter int          ADDR_W  = 3,
  parameter int          PRE_CYC = 1,
  parameter logic [63:0] INIT    = 64'h0484_F636_36A6_1604
) (
  input  logic            clk1,
  input  logic            rst,
  input  logic            sweep_en,
  output logic            precharge_n,
  output logic            sweep_wrap,
  rom_dyn_reader_if.slave bus
);

  localparam int INIT_W = 64;
  localparam int CNT_W  = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;

  localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PRE_CYC - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_EVAL = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  pre_cnt_r;
  logic [ADDR_W-1:0] addr_r;        // address of the word being read
  logic [ADDR_W-1:0] ptr_r;         // sweep pointer
  logic              sweep_word_r;  // current word was started by the sweep
  logic              sweep_wrap_r;
  logic [DATA_W-1:0] bitline_r;     // model of the precharged bitlines
  logic              rd_valid_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [DATA_W-1:0] display_r;

  logic [DATA_W-1:0] word_s;
  logic [DATA_W-1:0] bitline_eval_s;

  // Stored word at address a.
  // Cells that fall outside the INIT image are unprogrammed and read 0.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    int                idx;
    logic [5:0]        sel;
    w = '0;
    for (int i = 0; i < DATA_W; i++) begin
      idx = int'(a) * DATA_W + i;
      if (idx < INIT_W) begin
        sel  = idx[5:0];
        w[i] = INIT[sel];
      end else begin
        w[i] = 1'b0;
      end
    end
    return w;
  endfunction

  // Evaluate step: a programmed cell (bit = 1) discharges its precharged bitline.
  always_comb begin
    word_s         = '0;
    bitline_eval_s = '1;
    word_s         = rom_word(addr_r);
    bitline_eval_s = bitline_r & ~word_s;
  end

  // Requests are only taken in IDLE, never while sweeping, and never during reset.
  assign bus.req_ready = (state_r == ST_IDLE) && !sweep_en && !rst;
  assign precharge_n   = (state_r != ST_PRE);
  assign sweep_wrap    = sweep_wrap_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_addr   = rd_addr_r;
  assign bus.display   = display_r;

  // Read sequencer: phase control, address selection and sweep pointer.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pre_cnt_r    <= '0;
      addr_r       <= '0;
      ptr_r        <= '0;
      sweep_word_r <= 1'b0;
      sweep_wrap_r <= 1'b0;
    end else begin
      sweep_wrap_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (sweep_en) begin
            addr_r       <= ptr_r;
            sweep_word_r <= 1'b1;
            pre_cnt_r    <= '0;
            state_r      <= ST_PRE;
          end else begin
            ptr_r <= '0;
            if (bus.req_valid && bus.req_ready) begin
              addr_r       <= bus.req_addr;
              sweep_word_r <= 1'b0;
              pre_cnt_r    <= '0;
              state_r      <= ST_PRE;
            end
          end
        end
        ST_PRE: begin
          if (pre_cnt_r == PRE_LAST) begin
            state_r <= ST_EVAL;
          end else begin
            pre_cnt_r <= pre_cnt_r + CNT_W'(1);
          end
        end
        ST_EVAL: begin
          state_r <= ST_HOLD;
        end
        ST_HOLD: begin
          if (rd_valid_r && bus.rd_ready) begin
            if (sweep_en) begin
              // A word that came from the request port does not advance the
              // pointer, so the sweep starts from the pointer's current value.
              if (sweep_word_r) begin
                ptr_r        <= ptr_r + ADDR_W'(1);
                addr_r       <= ptr_r + ADDR_W'(1);
                sweep_wrap_r <= (ptr_r == PTR_LAST);
              end else begin
                addr_r <= ptr_r;
              end
              sweep_word_r <= 1'b1;
              pre_cnt_r    <= '0;
              state_r      <= ST_PRE;
            end else begin
              ptr_r        <= '0;
              sweep_word_r <= 1'b0;
              state_r      <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Bitline / output datapath.
  // Bitlines are precharged during PRE and discharged during EVAL, when the
  // word is captured. The captured word stays on display after rd_valid drops.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      bitline_r  <= '1;
      rd_valid_r <= 1'b0;
      rd_addr_r  <= '0;
      display_r  <= '0;
    end else begin
      case (state_r)
        ST_PRE: begin
          bitline_r <= '1;
        end
        ST_EVAL: begin
          bitline_r  <= bitline_eval_s;
          display_r  <= ~bitline_eval_s;
          rd_addr_r  <= addr_r;
          rd_valid_r <= 1'b1;
        end
        ST_HOLD: begin
          if (rd_valid_r && bus.rd_ready) begin
            rd_valid_r <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
